// File: rtl/tune_seq_player_if.sv
// Control, status and song-ROM signals of the tune sequencer, bundled as one interface.
// The player drives the ROM address and status; the host/ROM side drives the rest.
interface tune_seq_player_if #(
  parameter int unsigned VOICES = 2,
  parameter int unsigned SONGS  = 4,
  parameter int unsigned STEPS  = 16,
  parameter int unsigned DIV_W  = 8
);
  localparam int unsigned SEL_W  = (SONGS > 1) ? $clog2(SONGS) : 1;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic                      start;
  logic                      stop;
  logic                      loop;
  logic [SEL_W-1:0]          song_sel;
  logic [SEL_W+STEP_W-1:0]   rom_addr;
  logic [VOICES*DIV_W+3:0]   rom_data;
  logic [2*VOICES-1:0]       speaker;
  logic                      busy;
  logic                      done;
  logic [STEP_W-1:0]         step_idx;

  modport master (
    input  start, stop, loop, song_sel, rom_data,
    output rom_addr, speaker, busy, done, step_idx
  );

  modport slave (
    output start, stop, loop, song_sel, rom_data,
    input  rom_addr, speaker, busy, done, step_idx
  );
endinterface

// File: rtl/tune_seq_player.sv
// Multi-voice tune sequencer: walks a song in a synchronous ROM and drives one
// square-wave tone generator per voice onto complementary speaker pin pairs.
module tune_seq_player #(
  parameter int unsigned MAX_COUNT  = 12500,
  parameter int unsigned BEAT_TICKS = 250,
  parameter int unsigned VOICES     = 2,
  parameter int unsigned SONGS      = 4,
  parameter int unsigned STEPS      = 16,
  parameter int unsigned DIV_W      = 8
) (
  input logic               clk,
  input logic               rst,
  tune_seq_player_if.master bus
);
  localparam int unsigned SEL_W  = (SONGS > 1) ? $clog2(SONGS) : 1;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned DATA_W = VOICES * DIV_W + 4;
  localparam int unsigned PRE_W  = $clog2(MAX_COUNT);
  localparam int unsigned REM_W  = $clog2(8 * BEAT_TICKS + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StPlay} state_e;

  state_e                         state_q, state_d;
  logic [SEL_W-1:0]               song_q, song_d;
  logic [STEP_W-1:0]              step_q, step_d;
  logic                           end_q, end_d;
  logic [VOICES-1:0][DIV_W-1:0]   div_q, div_d;
  logic [VOICES-1:0][DIV_W-1:0]   cnt_q, cnt_d;
  logic [VOICES-1:0]              tone_q, tone_d;
  logic [PRE_W-1:0]               pre_q, pre_d;
  logic [REM_W-1:0]               rem_q, rem_d;
  logic                           done_q, done_d;

  logic                           tick;
  logic [2:0]                     rom_len;
  logic [2*VOICES-1:0]            speaker;

  assign tick    = (state_q == StPlay) && (pre_q == PRE_W'(MAX_COUNT - 1));
  assign rom_len = bus.rom_data[DATA_W-2 -: 3];

  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    step_d  = step_q;
    end_d   = end_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    tone_d  = tone_q;
    pre_d   = pre_q;
    rem_d   = rem_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        pre_d = '0;
        if (bus.start && !bus.stop) begin
          song_d  = bus.song_sel;
          step_d  = '0;
          div_d   = '0;
          cnt_d   = '0;
          tone_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        end_d = bus.rom_data[DATA_W-1];
        rem_d = REM_W'((32'(rom_len) + 32'd1) * BEAT_TICKS);
        for (int v = 0; v < VOICES; v++) begin
          div_d[v] = bus.rom_data[v*DIV_W +: DIV_W];
        end
        cnt_d   = '0;
        tone_d  = '0;
        pre_d   = '0;
        state_d = StPlay;
      end
      StPlay: begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        if (tick) begin
          for (int v = 0; v < VOICES; v++) begin
            if (div_q[v] == '0) begin
              cnt_d[v] = '0;
            end else if (cnt_q[v] == div_q[v] - DIV_W'(1)) begin
              cnt_d[v]  = '0;
              tone_d[v] = ~tone_q[v];
            end else begin
              cnt_d[v] = cnt_q[v] + DIV_W'(1);
            end
          end
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            // The last step of a song slot always ends the song.
            if (!end_q && (step_q != STEP_W'(STEPS - 1))) begin
              step_d  = step_q + STEP_W'(1);
              state_d = StFetch;
            end else if (bus.loop) begin
              step_d  = '0;
              state_d = StFetch;
            end else begin
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over a coincident end-of-step.
    if ((state_q != StIdle) && bus.stop) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      song_q  <= '0;
      step_q  <= '0;
      end_q   <= 1'b0;
      div_q   <= '0;
      cnt_q   <= '0;
      tone_q  <= '0;
      pre_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      step_q  <= step_d;
      end_q   <= end_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      tone_q  <= tone_d;
      pre_q   <= pre_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    speaker = '0;
    if (state_q != StIdle) begin
      for (int v = 0; v < VOICES; v++) begin
        if (div_q[v] != '0) begin
          speaker[2*v +: 2] = {~tone_q[v], tone_q[v]};
        end
      end
    end
  end

  assign bus.speaker  = speaker;
  assign bus.rom_addr = {song_q, step_q};
  assign bus.step_idx = step_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_tune_seq_player.sv
// Directed bench for tune_seq_player: small timebase, hand-computed step timing
// and speaker patterns, with a registered ROM model.
module tb_tune_seq_player;
  localparam int unsigned MAX_COUNT  = 4;
  localparam int unsigned BEAT_TICKS = 8;
  localparam int unsigned VOICES     = 2;
  localparam int unsigned SONGS      = 4;
  localparam int unsigned STEPS      = 4;
  localparam int unsigned DIV_W      = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic watch_addr;
  logic bad_addr;

  logic [11:0] rom [16];

  tune_seq_player_if #(
    .VOICES(VOICES),
    .SONGS (SONGS),
    .STEPS (STEPS),
    .DIV_W (DIV_W)
  ) bus ();

  tune_seq_player #(
    .MAX_COUNT (MAX_COUNT),
    .BEAT_TICKS(BEAT_TICKS),
    .VOICES    (VOICES),
    .SONGS     (SONGS),
    .STEPS     (STEPS),
    .DIV_W     (DIV_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // Song 2 must never spill into song 3's first word.
  always @(posedge clk) if (watch_addr && bus.busy && bus.rom_addr == 4'd12) bad_addr = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    watch_addr = 1'b0;
    bad_addr = 1'b0;
    // Word: {end, len[2:0], div1[3:0], div0[3:0]}
    for (int i = 0; i < 16; i++) rom[i] = 12'h011;
    rom[0]  = 12'h021;   // end0 len0 div1=2 div0=1
    rom[1]  = 12'h100;   // end0 len1 rest
    rom[2]  = 12'h811;   // end1 len0
    rom[3]  = 12'h033;
    rom[4]  = 12'h803;   // song 1: single note, voice 1 resting
    for (int i = 8; i < 12; i++) rom[i] = 12'h001;  // song 2: no end flag
    rom[12] = 12'h811;

    rst = 1'b0;
    bus.start = 1'b1;
    bus.stop = 1'b0;
    bus.loop = 1'b0;
    bus.song_sel = 2'd1;
    adv(2);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_spk", bus.speaker, 0);
    check("rst_addr", bus.rom_addr, 0);
    check("rst_idx", bus.step_idx, 0);
    bus.start = 1'b0;
    rst = 1'b1;
    adv(1);
    check("rst_nofetch", bus.busy, 0);

    // Single note, song 1
    bus.song_sel = 2'd1;
    bus.start = 1'b1;
    adv(1);
    bus.start = 1'b0;
    check("one_busy", bus.busy, 1);
    check("one_addr", bus.rom_addr, 4);
    adv(1);
    check("one_fetch_spk", bus.speaker, 0);
    adv(1);
    check("one_spk_k0", bus.speaker, 4'b0010);
    for (int k = 1; k < 32; k++) begin
      adv(1);
      check("one_spk", bus.speaker, ((k >= 12) ^ (k >= 24)) ? 4'b0001 : 4'b0010);
      check("one_nodone", bus.done, 0);
    end
    adv(1);
    check("one_done", bus.done, 1);
    check("one_busy_fall", bus.busy, 0);
    check("one_spk_idle", bus.speaker, 0);
    adv(1);
    check("one_done_pulse", bus.done, 0);

    // Three-step sequence, song 0
    bus.song_sel = 2'd0;
    bus.start = 1'b1;
    adv(1);
    bus.start = 1'b0;
    check("seq_addr0", bus.rom_addr, 0);
    check("seq_idx0", bus.step_idx, 0);
    adv(2);
    check("seq_spk_load", bus.speaker, 4'b1010);
    adv(4);
    check("seq_spk_tick", bus.speaker, 4'b1001);
    adv(27);
    check("seq_addr0_hold", bus.rom_addr, 0);
    adv(1);
    check("seq_addr1", bus.rom_addr, 1);
    check("seq_idx1", bus.step_idx, 1);
    adv(1);
    check("seq_spk_held", bus.speaker, 4'b1010);
    adv(2);
    check("seq_spk_rest", bus.speaker, 0);
    adv(62);
    check("seq_addr1_hold", bus.rom_addr, 1);
    adv(1);
    check("seq_addr2", bus.rom_addr, 2);
    check("seq_idx2", bus.step_idx, 2);
    adv(33);
    check("seq_busy_end", bus.busy, 1);
    check("seq_nodone", bus.done, 0);
    adv(1);
    check("seq_done", bus.done, 1);
    check("seq_busy_fall", bus.busy, 0);

    // Max-step end, song 2
    adv(2);
    watch_addr = 1'b1;
    bus.song_sel = 2'd2;
    bus.start = 1'b1;
    adv(1);
    bus.start = 1'b0;
    check("max_addr0", bus.rom_addr, 8);
    for (int s = 1; s < 4; s++) begin
      adv(34);
      check("max_addr", bus.rom_addr, 8 + s);
    end
    adv(34);
    check("max_done", bus.done, 1);
    check("max_busy", bus.busy, 0);
    check("max_addr_final", bus.rom_addr, 11);
    check("max_idx_final", bus.step_idx, 3);
    adv(2);
    watch_addr = 1'b0;
    check("max_no_spill", bad_addr, 0);

    // Loop mode, song 0
    bus.song_sel = 2'd0;
    bus.loop = 1'b1;
    bus.start = 1'b1;
    adv(1);
    bus.start = 1'b0;
    adv(133);
    check("loop_addr_pre", bus.rom_addr, 2);
    adv(1);
    check("loop_addr_wrap", bus.rom_addr, 0);
    check("loop_busy", bus.busy, 1);
    check("loop_nodone", bus.done, 0);
    bus.loop = 1'b0;
    adv(134);
    check("loop_done", bus.done, 1);
    check("loop_busy_fall", bus.busy, 0);

    // Abort, with start ignored while busy
    adv(2);
    bus.song_sel = 2'd0;
    bus.start = 1'b1;
    adv(1);
    bus.start = 1'b0;
    adv(5);
    bus.song_sel = 2'd3;
    bus.start = 1'b1;
    adv(1);
    check("abort_start_ign", bus.rom_addr, 0);
    check("abort_busy", bus.busy, 1);
    bus.start = 1'b0;
    adv(3);
    bus.stop = 1'b1;
    adv(1);
    check("abort_idle", bus.busy, 0);
    check("abort_spk", bus.speaker, 0);
    check("abort_nodone", bus.done, 0);
    bus.stop = 1'b0;
    adv(2);
    check("abort_nodone2", bus.done, 0);

    // start and stop together in IDLE
    bus.start = 1'b1;
    bus.stop = 1'b1;
    adv(2);
    check("startstop_idle", bus.busy, 0);
    bus.start = 1'b0;
    bus.stop = 1'b0;

    // Reset mid-play
    bus.song_sel = 2'd2;
    bus.start = 1'b1;
    adv(1);
    bus.start = 1'b0;
    adv(10);
    rst = 1'b0;
    adv(1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_addr", bus.rom_addr, 0);
    check("midrst_spk", bus.speaker, 0);
    rst = 1'b1;
    adv(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tune_seq_player.md
# tune_seq_player

Parametrised multi-voice tune sequencer: the successor to the single-tune TT02 player. It steps through a song stored in an external ROM, with up to `SONGS` songs selectable at start. Each step drives `VOICES` independent square-wave tone generators onto complementary speaker pin pairs. It adds start/stop control, loop mode, per-step durations and rests, and sits between the `io_in`/`io_out` pad wrapper and a synchronous song ROM.

## Interface
- `MAX_COUNT`, 12500: clk cycles per timebase tick; must be ≥ 2.
- `BEAT_TICKS`, 250: ticks per duration unit.
- `VOICES`, 2: tone channels, 1–4.
- `SONGS`, 4: selectable songs; `SEL_W` = clog2(`SONGS`), minimum 1.
- `STEPS`, 16: steps per song, a power of 2; `STEP_W` = clog2(`STEPS`).
- `DIV_W`, 8: tone divider width.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: reset is synchronous and active-low (0 = reset).
- `start` input 1: level, sampled only in IDLE.
- `stop` input 1: level, aborts playback.
- `loop` input 1: when 1, the end of the song restarts at step 0.
- `song_sel` input `SEL_W`: song index, latched on start.
- `rom_addr` output `SEL_W+STEP_W`: registered address `{song, step}`.
- `rom_data` input `VOICES*DIV_W+4`: ROM word, valid 1 cycle after `rom_addr`.
  - `[VOICES*DIV_W+3]` = end flag.
  - `[VOICES*DIV_W+2:VOICES*DIV_W]` = len.
  - Voice v divider at `[v*DIV_W +: DIV_W]`.
- `speaker` output `2*VOICES`: pair v = `{~tone_v, tone_v}`, or `00` when silent.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: single-cycle pulse on normal song end.
- `step_idx` output `STEP_W`: index of the current step.

## Operation
- FSM states: IDLE, FETCH, LOAD, PLAY.
- IDLE:
  - speaker = 0.
  - `start`=1 and `stop`=0 → latch `song_sel`, step = 0, set `rom_addr` = `{song,0}`, go to FETCH.
- FETCH: waits exactly 1 cycle, then goes to LOAD.
- LOAD (1 cycle):
  - Capture `rom_data` into the note registers.
  - Clear the prescaler and all tone counters; force tone_v = 0.
  - Load remaining = (len+1)·`BEAT_TICKS` ticks.
  - Go to PLAY.
- Prescaler: counts 0..`MAX_COUNT`-1 in PLAY; the cycle with count = `MAX_COUNT`-1 is a tick.
- Tone generator, voice v with div ≠ 0:
  - Counter increments per tick.
  - When counter = div-1, toggle tone_v and clear the counter.
  - Resulting period = 2·div·`MAX_COUNT` cycles.
- A voice with div = 0 is a rest: pair = `00`, counter held at 0.
- PLAY, on the tick where remaining reaches 0:
  - End flag = 0 and step ≠ `STEPS`-1 → step+1, `rom_addr` updated, go to FETCH.
  - Otherwise, if `loop`=1 (sampled on this tick) → step = 0, go to FETCH.
  - Otherwise → go to IDLE and pulse `done`.
- Step `STEPS`-1 is always treated as the end of the song (no wrap into the next song).
- `stop`=1 in any non-IDLE state → IDLE on the next edge:
  - speaker = 0, no `done` pulse.
  - `stop` has priority over a simultaneous end-of-step.
- `start` while busy is ignored; `song_sel` changes while busy are ignored.
- `start` and `stop` both high in IDLE → stay in IDLE.

## Timing
- Reset values: speaker = 0, `rom_addr` = 0, `busy` = 0, `done` = 0, `step_idx` = 0; all counters cleared; FSM in IDLE.
- Reset mid-play has the same effect on the next edge.
- `start` sampled at edge N:
  - `busy` = 1 and `rom_addr` valid after edge N.
  - `rom_data` sampled at edge N+2.
  - Speaker active from edge N+2.
- Each step occupies (len+1)·`BEAT_TICKS`·`MAX_COUNT` cycles in PLAY, plus 2 cycles (FETCH + LOAD).
- Speaker is held at the previous note during FETCH/LOAD.
- `done` is high for the single cycle after the final PLAY edge; `busy` falls on the same edge.
- `step_idx` and `rom_addr` update on the same edge.

## Test plan
Bench settings: `MAX_COUNT`=4, `BEAT_TICKS`=8, `VOICES`=2, `DIV_W`=4, `STEPS`=4.

- Reset: hold `rst`=0 for 2 cycles with `start`=1 → speaker = 0, `busy` = 0, `done` = 0, `rom_addr` = 0; no FETCH.
- Single note: song 1, step 0 = {end=1, len=0, div1=0, div0=3}, pulse `start` → `rom_addr` = 4.
  - speaker[1:0] = `10`, then toggles 12 and 24 cycles after LOAD.
  - speaker[3:2] = `00`.
  - `done` pulses 32 cycles after LOAD; `busy` falls on the same edge.
- Sequence: song 0 = steps 0–2, end flag on step 2 → `rom_addr` goes 0, 1, 2; `step_idx` matches; each step's PLAY lasts (len+1)·32 cycles.
- Max-step end: song with no end flag → stops after step 3 with `done`, never addresses `{song+1,0}`.
- Loop: `loop`=1 on the same song → after step 2 `rom_addr` returns to 0, no `done`; dropping `loop` ends the song at the next end flag.
- Abort: `stop`=1 mid-PLAY → IDLE and speaker = 0 on the next edge, no `done`; `start` while busy does not change `rom_addr`.
